// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and round-robin pick helper for the register-bank write arbiter
package regfile_arb_pkg;

   localparam int NREQ_DEF = 4;
   localparam int MAX_REQ  = 32;
   localparam int MAX_SEL  = 5;

   typedef logic [$clog2(NREQ_DEF)-1:0] ptr_t;

   // One-hot grant for the first set bit of valid[nreq-1:0], searching
   // upward from ptr and wrapping at nreq. Zero when nothing is valid.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input int unsigned        ptr,
                                                  input int unsigned        nreq);
      logic [MAX_REQ-1:0] grant;
      logic [MAX_SEL-1:0] sel;
      logic               found;
      grant = '0;
      found = 1'b0;
      sel   = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         if (k < nreq && !found) begin
            sel = MAX_SEL'((ptr + k) % nreq);
            if (valid[sel]) begin
               grant[sel] = 1'b1;
               found      = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rtl/regfile_write_arbiter_rr_arbiter.sv - round-robin arbiter with registered rotating pointer
//   clk, rst_n : clock and asynchronous active-low reset
//   valid      : per-requester request
//   grant      : combinational one-hot grant, zero when no request
module rr_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] valid,
   output logic [NREQ-1:0] grant
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]      ptr;
   logic [PW-1:0]      ptr_nxt;
   logic [MAX_REQ-1:0] pick;

   assign pick  = rr_pick(MAX_REQ'(valid), 32'(ptr), NREQ);
   assign grant = pick[NREQ-1:0];

   // Upper pick bits are always zero; folded here so they are not dangling.
   generate
      if (NREQ < MAX_REQ) begin : g_unused
         logic unused_pick_hi;
         assign unused_pick_hi = |pick[MAX_REQ-1:NREQ];
      end
   endgenerate

   // Pointer moves to one past the winner; holds when idle.
   always_comb begin
      ptr_nxt = ptr;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_nxt;
   end

endmodule

// File: rtl/register_en.sv
// rtl/register_en.sv - enable-gated storage word without reset
//   clk : rising-edge clock
//   en  : load d into q on this edge
//   d   : write data
//   q   : stored word
module register_en #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (en) q <= d;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin shared write port into a masked register bank
//   clk, rst_n          : clock and asynchronous active-low reset
//   req_valid/req_ready : per-requester write handshake, ready is the one-hot grant
//   req_addr/req_data   : packed per-requester address and data
//   rd_addr/rd_data     : combinational read port, zero for unwritten or out-of-range words
//   rd_valid            : addressed word has been written since reset
//   wr_err              : one-cycle pulse after an accepted out-of-range write
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DEPTH = 8,
   parameter int WIDTH = 32,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*AW-1:0]    req_addr,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [AW-1:0]         rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  rd_valid,
   output logic                  wr_err
);

   localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

   logic [NREQ-1:0]  grant;
   logic             wr_fire;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             wr_in_range;
   logic [DEPTH-1:0] word_en;
   logic [DEPTH-1:0] entry_valid;
   logic [WIDTH-1:0] words [DEPTH];
   logic [WIDTH-1:0] rd_word;
   logic             rd_hit_valid;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .valid (req_valid),
      .grant (grant)
   );

   assign req_ready = grant;

   // Grant is one-hot, so at most one requester drives the write bus.
   always_comb begin
      wr_fire = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            wr_fire = 1'b1;
            wr_addr = req_addr[i*AW +: AW];
            wr_data = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;

   generate
      for (genvar j = 0; j < DEPTH; j++) begin : g_word
         assign word_en[j] = wr_fire && wr_in_range && (wr_addr == AW'(j));

         register_en #(.WIDTH(WIDTH)) u_word (
            .clk (clk),
            .en  (word_en[j]),
            .d   (wr_data),
            .q   (words[j])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_valid <= '0;
         wr_err      <= 1'b0;
      end else begin
         entry_valid <= entry_valid | word_en;
         wr_err      <= wr_fire && !wr_in_range;
      end
   end

   // Out-of-range addresses match no word and fall through to zero.
   always_comb begin
      rd_word      = '0;
      rd_hit_valid = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         if (rd_addr == AW'(j)) begin
            rd_word      = words[j];
            rd_hit_valid = entry_valid[j];
         end
      end
   end

   assign rd_valid = rd_hit_valid;
   assign rd_data  = rd_hit_valid ? rd_word : '0;

endmodule
